// File: rtl/flash_adc_pkg.sv
// Shared types, default parameters and helpers for the flash ADC back-end.
package flash_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    localparam int DEF_NCMP        = 15;
    localparam int DEF_AVG_LOG2    = 2;
    localparam int DEF_SYNC_STAGES = 2;

    // Widest ladder the popcount helper handles; callers zero-pad up to it.
    localparam int MAX_NCMP = 255;

    function automatic int unsigned thermo_popcount(input logic [MAX_NCMP-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_NCMP; i++) begin
            if (bits[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/thermo_encoder.sv
// Repairs single-bit bubbles in a thermometer word and registers its popcount.
module thermo_encoder
    import flash_adc_pkg::*;
#(
    parameter  int NCMP  = DEF_NCMP,
    localparam int OUT_W = $clog2(NCMP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCMP-1:0]  thermo,
    output logic [OUT_W-1:0] code
);

    logic [NCMP+1:0]     ext;
    logic [NCMP-1:0]     fixed;
    logic [MAX_NCMP-1:0] padded;

    // Below the ladder reads as 1 and above it as 0, so edge bits vote sensibly.
    assign ext = {1'b0, thermo, 1'b1};

    for (genvar i = 0; i < NCMP; i++) begin : g_vote
        assign fixed[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end

    always_comb begin
        padded            = '0;
        padded[NCMP-1:0]  = fixed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) code <= '0;
        else     code <= OUT_W'(thermo_popcount(padded));
    end

endmodule

// File: rtl/flash_adc_sampler.sv
// Flash ADC back-end: synchroniser, bubble-tolerant encoder, windowed averager
// with a valid/ready result register and sticky overrun flag.
module flash_adc_sampler
    import flash_adc_pkg::*;
#(
    parameter  int NCMP        = DEF_NCMP,
    localparam int OUT_W       = $clog2(NCMP + 1),
    parameter  int AVG_LOG2    = DEF_AVG_LOG2,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCMP-1:0]  thermo_in,
    input  logic             en,
    input  logic             cont,
    input  logic             start,
    output logic [OUT_W-1:0] code_o,
    output logic [OUT_W-1:0] avg_o,
    output logic             avg_valid,
    input  logic             avg_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = OUT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [NCMP-1:0]  sync_q [SYNC_STAGES];
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_q;
    logic             done, transfer, load, drop, dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= thermo_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    thermo_encoder #(.NCMP(NCMP)) u_encoder (
        .clk    (clk),
        .rst    (rst),
        .thermo (sync_q[SYNC_STAGES-1]),
        .code   (code_o)
    );

    assign sum      = acc_q + ACC_W'(code_o);
    assign transfer = avg_valid & avg_ready;
    assign busy     = (state_q == ACC);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (en && (cont || start)) state_d = ACC;
            ACC: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    done    = 1'b1;
                    state_d = cont ? ACC : HOLD;
                end
            end
            // A dropped one-shot result has nothing left to deliver.
            HOLD: if (!en || dropped_q || !avg_valid || avg_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load = done && (!avg_valid || transfer);
    assign drop = done && avg_valid && !transfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dropped_q <= drop;
            if (state_q != ACC || done) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_o     <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                avg_o     <= OUT_W'(sum >> AVG_LOG2);
                avg_valid <= 1'b1;
            end else if (transfer) begin
                avg_valid <= 1'b0;
            end
            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_adc_sampler.sv
// Randomised scenario bench for flash_adc_sampler against a behavioural model.
module tb_flash_adc_sampler;

    localparam int NCMP  = 15;
    localparam int OUT_W = 4;
    localparam int WIN   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCMP-1:0]  thermo_in;
    logic             en, cont, start, avg_ready, overrun_clr;
    logic [OUT_W-1:0] code_o, avg_o;
    logic             avg_valid, busy, overrun;

    int passed = 0;
    int total  = 0;

    logic [NCMP-1:0] h1, h2;
    int              exp_code;

    flash_adc_sampler #(.NCMP(NCMP), .AVG_LOG2(2), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .thermo_in   (thermo_in),
        .en          (en),
        .cont        (cont),
        .start       (start),
        .code_o      (code_o),
        .avg_o       (avg_o),
        .avg_valid   (avg_valid),
        .avg_ready   (avg_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Count of levels after each bit takes the majority of itself and its neighbours.
    function automatic int model_code(input logic [NCMP-1:0] t);
        int n, lo, hi, mid;
        n = 0;
        for (int i = 0; i < NCMP; i++) begin
            lo  = (i == 0) ? 1 : int'(t[i-1]);
            hi  = (i == NCMP - 1) ? 0 : int'(t[i+1]);
            mid = int'(t[i]);
            if (lo + mid + hi >= 2) n++;
        end
        return n;
    endfunction

    function automatic logic [NCMP-1:0] rand_thermo();
        logic [31:0]     w;
        logic [NCMP-1:0] v;
        int              lvl, b;
        lvl = int'($urandom_range(NCMP, 0));
        w   = (32'd1 << lvl) - 32'd1;
        v   = w[NCMP-1:0];
        if ($urandom_range(1, 0) == 1) begin
            b    = int'($urandom_range(NCMP - 1, 0));
            v[b] = ~v[b];
        end
        return v;
    endfunction

    // One clock: the code visible after the edge reflects the word applied two ticks earlier.
    task automatic tick(input logic [NCMP-1:0] t);
        thermo_in = t;
        exp_code  = model_code(h2);
        h2        = h1;
        h1        = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 0; cont = 0; start = 0; avg_ready = 0; overrun_clr = 0;
        thermo_in = '0; h1 = '0; h2 = '0; exp_code = 0;
        #1;
        total++; if (code_o !== 4'd0) $display("[TB] FAIL reset_code: got %0d expected 0", code_o); else passed++;
        total++; if (avg_o !== 4'd0) $display("[TB] FAIL reset_avg: got %0d expected 0", avg_o); else passed++;
        total++; if (avg_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", avg_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passed++;
        total++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %0b expected 0", overrun); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = (i == 2);
            tick('0);
            total++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %0b expected 0", busy); else passed++;
        end
        en = 0;
    endtask

    task automatic test_encode;
        repeat (3) tick('0);
        for (int i = 0; i < 3; i++) begin
            tick(15'h00FF);
            total++;
            if (code_o !== OUT_W'(exp_code)) $display("[TB] FAIL encode_latency[%0d]: got %0d expected %0d", i, code_o, exp_code);
            else passed++;
        end
        total++; if (code_o !== 4'd8) $display("[TB] FAIL encode_value: got %0d expected 8", code_o); else passed++;
    endtask

    task automatic test_bubble;
        repeat (3) tick(15'h005F);
        total++; if (code_o !== 4'd6) $display("[TB] FAIL bubble_fix: got %0d expected 6", code_o); else passed++;
        for (int i = 0; i < 20; i++) begin
            tick(rand_thermo());
            total++;
            if (code_o !== OUT_W'(exp_code)) $display("[TB] FAIL bubble_random[%0d]: got %0d expected %0d", i, code_o, exp_code);
            else passed++;
        end
    endtask

    task automatic test_oneshot(input bit fixed);
        logic [NCMP-1:0] v [4];
        int sum;
        for (int i = 0; i < 4; i++) v[i] = fixed ? NCMP'((32'd1 << (i + 4)) - 32'd1) : rand_thermo();
        en = 1; cont = 0; avg_ready = 0;
        tick(v[0]);
        tick(v[1]);
        start = 1;
        tick(v[2]);
        start = 0;
        sum = 0;
        for (int k = 0; k < WIN; k++) begin
            total++; if (busy !== 1'b1) $display("[TB] FAIL oneshot_busy[%0d]: got %0b expected 1", k, busy); else passed++;
            total++; if (avg_valid !== 1'b0) $display("[TB] FAIL oneshot_early[%0d]: got %0b expected 0", k, avg_valid); else passed++;
            sum += exp_code;
            tick(k == 0 ? v[3] : rand_thermo());
        end
        total++; if (avg_valid !== 1'b1) $display("[TB] FAIL oneshot_valid: got %0b expected 1", avg_valid); else passed++;
        total++; if (avg_o !== OUT_W'(sum >> 2)) $display("[TB] FAIL oneshot_avg: got %0d expected %0d", avg_o, sum >> 2); else passed++;
        start = 1;
        tick(rand_thermo());
        start = 0;
        total++; if (busy !== 1'b0) $display("[TB] FAIL hold_start: got busy %0b expected 0", busy); else passed++;
        total++; if (avg_valid !== 1'b1) $display("[TB] FAIL hold_valid: got %0b expected 1", avg_valid); else passed++;
        avg_ready = 1;
        tick(rand_thermo());
        avg_ready = 0;
        total++; if (avg_valid !== 1'b0) $display("[TB] FAIL hold_consume: got %0b expected 0", avg_valid); else passed++;
        tick(rand_thermo());
        total++; if (busy !== 1'b0) $display("[TB] FAIL hold_idle: got busy %0b expected 0", busy); else passed++;
    endtask

    task automatic test_abort;
        int sum;
        en = 1; cont = 0; start = 1;
        tick(rand_thermo());
        start = 0;
        tick(rand_thermo());
        tick(rand_thermo());
        en = 0;
        tick(rand_thermo());
        total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %0b expected 0", busy); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick(rand_thermo());
            total++; if (avg_valid !== 1'b0) $display("[TB] FAIL abort_valid[%0d]: got %0b expected 0", i, avg_valid); else passed++;
        end
        en = 1; start = 1;
        tick(rand_thermo());
        start = 0;
        sum = 0;
        for (int k = 0; k < WIN; k++) begin
            total++; if (avg_valid !== 1'b0) $display("[TB] FAIL refill_early[%0d]: got %0b expected 0", k, avg_valid); else passed++;
            sum += exp_code;
            tick(rand_thermo());
        end
        total++; if (avg_valid !== 1'b1) $display("[TB] FAIL refill_valid: got %0b expected 1", avg_valid); else passed++;
        total++; if (avg_o !== OUT_W'(sum >> 2)) $display("[TB] FAIL refill_avg: got %0d expected %0d", avg_o, sum >> 2); else passed++;
        avg_ready = 1;
        tick(rand_thermo());
        avg_ready = 0; en = 0;
        tick(rand_thermo());
    endtask

    task automatic test_overrun;
        int s1, s2;
        en = 1; cont = 1; avg_ready = 0; overrun_clr = 0;
        tick(rand_thermo());
        s1 = 0;
        for (int k = 0; k < WIN; k++) begin s1 += exp_code; tick(rand_thermo()); end
        total++; if (avg_o !== OUT_W'(s1 >> 2)) $display("[TB] FAIL ovr_first: got %0d expected %0d", avg_o, s1 >> 2); else passed++;
        for (int k = 0; k < WIN; k++) tick(rand_thermo());
        total++; if (avg_o !== OUT_W'(s1 >> 2)) $display("[TB] FAIL ovr_retained: got %0d expected %0d", avg_o, s1 >> 2); else passed++;
        total++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_set: got %0b expected 1", overrun); else passed++;
        overrun_clr = 1;
        tick(rand_thermo());
        overrun_clr = 0;
        total++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_clear: got %0b expected 0", overrun); else passed++;
        en = 0;
        tick(rand_thermo());
        avg_ready = 1;
        tick(rand_thermo());
        avg_ready = 0; en = 1;
        tick(rand_thermo());
        s1 = 0;
        for (int k = 0; k < WIN; k++) begin s1 += exp_code; tick(rand_thermo()); end
        total++; if (avg_o !== OUT_W'(s1 >> 2)) $display("[TB] FAIL ovr2_first: got %0d expected %0d", avg_o, s1 >> 2); else passed++;
        s2 = 0;
        for (int k = 0; k < WIN; k++) begin
            s2 += exp_code;
            avg_ready = (k == WIN - 1);
            tick(rand_thermo());
        end
        avg_ready = 0;
        total++; if (avg_o !== OUT_W'(s2 >> 2)) $display("[TB] FAIL ovr2_loaded: got %0d expected %0d", avg_o, s2 >> 2); else passed++;
        total++; if (avg_valid !== 1'b1) $display("[TB] FAIL ovr2_valid: got %0b expected 1", avg_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("[TB] FAIL ovr2_noflag: got %0b expected 0", overrun); else passed++;
        en = 0; cont = 0;
        tick(rand_thermo());
        avg_ready = 1;
        tick(rand_thermo());
        avg_ready = 0;
    endtask

    task automatic test_back_to_back;
        bit mvalid, movr, xfer, drop, rdy, clr;
        int mavg, sum;
        mvalid = 0; movr = 0; mavg = 0;
        en = 1; cont = 1;
        tick(rand_thermo());
        for (int w = 0; w < 8; w++) begin
            sum = 0;
            for (int k = 0; k < WIN; k++) begin
                sum += exp_code;
                rdy = ($urandom_range(1, 0) == 1);
                clr = ($urandom_range(7, 0) == 0);
                avg_ready = rdy; overrun_clr = clr;
                xfer = mvalid && rdy;
                drop = 0;
                if (k == WIN - 1) begin
                    if (!mvalid || xfer) begin mvalid = 1; mavg = sum / WIN; end
                    else drop = 1;
                end else if (xfer) begin
                    mvalid = 0;
                end
                if (drop) movr = 1;
                else if (clr) movr = 0;
                tick(rand_thermo());
                total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_busy[%0d.%0d]: got %0b expected 1", w, k, busy); else passed++;
                total++; if (avg_valid !== mvalid) $display("[TB] FAIL b2b_valid[%0d.%0d]: got %0b expected %0b", w, k, avg_valid, mvalid); else passed++;
                total++; if (overrun !== movr) $display("[TB] FAIL b2b_overrun[%0d.%0d]: got %0b expected %0b", w, k, overrun, movr); else passed++;
                total++; if (code_o !== OUT_W'(exp_code)) $display("[TB] FAIL b2b_code[%0d.%0d]: got %0d expected %0d", w, k, code_o, exp_code); else passed++;
                if (mvalid) begin
                    total++; if (avg_o !== OUT_W'(mavg)) $display("[TB] FAIL b2b_avg[%0d.%0d]: got %0d expected %0d", w, k, avg_o, mavg); else passed++;
                end
            end
        end
        en = 0; cont = 0; avg_ready = 1; overrun_clr = 1;
        tick(rand_thermo());
        avg_ready = 0; overrun_clr = 0;
        tick(rand_thermo());
    endtask

    task automatic test_reset_mid;
        en = 1; cont = 0; start = 1;
        tick(rand_thermo());
        start = 0;
        repeat (WIN) tick(rand_thermo());
        en = 0;
        tick(rand_thermo());
        en = 1; cont = 1;
        tick(rand_thermo());
        tick(rand_thermo());
        total++; if (avg_valid !== 1'b1) $display("[TB] FAIL mid_pre_valid: got %0b expected 1", avg_valid); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL mid_pre_busy: got %0b expected 1", busy); else passed++;
        rst = 1; thermo_in = '0; h1 = '0; h2 = '0;
        #1;
        total++; if (avg_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %0b expected 0", avg_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %0b expected 0", busy); else passed++;
        total++; if (avg_o !== 4'd0) $display("[TB] FAIL mid_avg: got %0d expected 0", avg_o); else passed++;
        total++; if (code_o !== 4'd0) $display("[TB] FAIL mid_code: got %0d expected 0", code_o); else passed++;
        total++; if (overrun !== 1'b0) $display("[TB] FAIL mid_overrun: got %0b expected 0", overrun); else passed++;
        en = 0; cont = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            en = (i >= 2);
            tick('0);
            total++; if (busy !== 1'b0) $display("[TB] FAIL mid_idle[%0d]: got %0b expected 0", i, busy); else passed++;
        end
        cont = 1;
        tick('0);
        total++; if (busy !== 1'b1) $display("[TB] FAIL mid_restart: got %0b expected 1", busy); else passed++;
        en = 0; cont = 0;
        tick('0);
    endtask

    initial begin
        test_reset;
        test_encode;
        test_bubble;
        test_oneshot(1'b1);
        test_oneshot(1'b0);
        test_abort;
        test_overrun;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
